// File: rtl/idma_w_burst_tracker_pkg.sv
// Shared types and helpers for the iDMA write-side burst tracker.
// Optional feature macro: IDMA_BTRACK_ERR_ADDR_EN (see idma_w_burst_tracker.sv).
package idma_w_burst_tracker_pkg;

    // Widest burst address the tracker entry type can carry.
    localparam int unsigned BtrackMaxAddrWidth = 64;

    // AXI B response encoding.
    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExOkay = 2'b01,
        RespSlvErr = 2'b10,
        RespDecErr = 2'b11
    } resp_t;

    // One entry per emitted AW burst.
    typedef struct packed {
        logic                          last;
        logic                          super_last;
        logic [BtrackMaxAddrWidth-1:0] addr;
    } btrack_entry_t;

    // SLVERR and DECERR both have bit 1 set; OKAY and EXOKAY are success.
    function automatic logic is_err(input resp_t resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/idma_w_burst_tracker_fifo.sv
// Non-fall-through FIFO holding outstanding AW burst records.
// Depth must be a power of two so pointers wrap naturally.
module idma_w_burst_tracker_fifo #(
    parameter int unsigned Depth     = 8,
    parameter int unsigned DataWidth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [PtrWidth-1:0]  r_wr_ptr;
    logic [PtrWidth-1:0]  r_rd_ptr;
    logic [CntWidth-1:0]  r_cnt;
    logic [DataWidth-1:0] r_mem [Depth];

    logic                 w_push;
    logic                 w_pop;
    logic [PtrWidth-1:0]  w_wr_ptr_d;
    logic [PtrWidth-1:0]  w_rd_ptr_d;
    logic [CntWidth-1:0]  w_cnt_d;

    assign full_o  = (r_cnt == CntWidth'(Depth));
    assign empty_o = (r_cnt == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = r_mem[r_rd_ptr];

    // Pointer and occupancy next state; push+pop together leaves occupancy unchanged.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_cnt_d    = r_cnt;
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr + PtrWidth'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr + PtrWidth'(1);
        end
        if (w_push && !w_pop) begin
            w_cnt_d = r_cnt + CntWidth'(1);
        end else if (!w_push && w_pop) begin
            w_cnt_d = r_cnt - CntWidth'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_d;
            r_rd_ptr <= w_rd_ptr_d;
            r_cnt    <= w_cnt_d;
        end
    end

    // Storage array, written at the write pointer on an accepted push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/idma_w_burst_tracker.sv
// Tracks AW bursts emitted by the 1D write legalizer, retires them in order against
// AXI B responses and emits one completion per legalized 1D transfer with a sticky
// error flag.
// Optional feature macro: IDMA_BTRACK_ERR_ADDR_EN -- when defined, the burst address is
// stored per entry and the address of the first failing burst of a transfer is reported
// on rsp_err_addr_o; otherwise rsp_err_addr_o is tied to zero.
module idma_w_burst_tracker
    import idma_w_burst_tracker_pkg::*;
#(
    parameter int unsigned NumOutstanding = 8,
    parameter int unsigned AddrWidth      = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic                 aw_last_i,
    input  logic                 aw_super_last_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 b_valid_i,
    output logic                 b_ready_o,
    input  logic [1:0]           b_resp_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_error_o,
    output logic                 rsp_last_o,
    output logic [AddrWidth-1:0] rsp_err_addr_o,
    output logic                 busy_o
);

`ifdef IDMA_BTRACK_ERR_ADDR_EN
    localparam int unsigned EntryWidth = 2 + AddrWidth;
`else
    localparam int unsigned EntryWidth = 2;
`endif

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [EntryWidth-1:0] w_fifo_wdata;
    logic [EntryWidth-1:0] w_fifo_rdata;
    btrack_entry_t         w_head;
    logic                  w_unused_head_addr;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_bresp_err;

    logic                  r_err;
    logic                  r_rsp_valid;
    logic                  r_rsp_error;
    logic                  r_rsp_last;
    logic                  w_err_d;
    logic                  w_rsp_valid_d;
    logic                  w_rsp_error_d;
    logic                  w_rsp_last_d;

`ifdef IDMA_BTRACK_ERR_ADDR_EN
    assign w_fifo_wdata = {aw_last_i, aw_super_last_i, aw_addr_i};
`else
    logic w_unused_aw_addr;
    assign w_fifo_wdata     = {aw_last_i, aw_super_last_i};
    assign w_unused_aw_addr = ^aw_addr_i;
`endif

    idma_w_burst_tracker_fifo #(
        .Depth     (NumOutstanding),
        .DataWidth (EntryWidth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (w_fifo_wdata),
        .pop_i   (w_pop),
        .data_o  (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Unpack the FIFO head into the shared entry type.
    always_comb begin
        w_head            = '0;
        w_head.last       = w_fifo_rdata[EntryWidth-1];
        w_head.super_last = w_fifo_rdata[EntryWidth-2];
`ifdef IDMA_BTRACK_ERR_ADDR_EN
        w_head.addr       = BtrackMaxAddrWidth'(w_fifo_rdata[AddrWidth-1:0]);
`endif
    end

    // Only the low AddrWidth bits of the entry address carry information.
    assign w_unused_head_addr = ^w_head.addr;

    // Full flag is registered, so a pop in the same cycle never opens the AW path early.
    assign aw_ready_o  = ~w_fifo_full;
    assign w_push      = aw_valid_i & aw_ready_o;
    // A last-burst B must wait until the single response slot is free or draining.
    assign b_ready_o   = ~w_fifo_empty & (~w_head.last | ~r_rsp_valid | rsp_ready_i);
    assign w_pop       = b_valid_i & b_ready_o;
    assign w_bresp_err = is_err(resp_t'(b_resp_i));

    // Sticky error and completion register next state.
    always_comb begin
        w_err_d       = r_err;
        w_rsp_valid_d = r_rsp_valid;
        w_rsp_error_d = r_rsp_error;
        w_rsp_last_d  = r_rsp_last;
        if (r_rsp_valid && rsp_ready_i) begin
            w_rsp_valid_d = 1'b0;
        end
        if (w_pop) begin
            if (w_head.last) begin
                // Load overrides a drain in the same cycle: no bubble between responses.
                w_rsp_valid_d = 1'b1;
                w_rsp_error_d = r_err | w_bresp_err;
                w_rsp_last_d  = w_head.super_last;
                w_err_d       = 1'b0;
            end else begin
                w_err_d = r_err | w_bresp_err;
            end
        end
    end

    // Sticky error and completion registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_err       <= w_err_d;
            r_rsp_valid <= w_rsp_valid_d;
            r_rsp_error <= w_rsp_error_d;
            r_rsp_last  <= w_rsp_last_d;
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_error_o = r_rsp_error;
    assign rsp_last_o  = r_rsp_last;
    assign busy_o      = ~w_fifo_empty | r_rsp_valid;

`ifdef IDMA_BTRACK_ERR_ADDR_EN
    logic [AddrWidth-1:0] r_err_addr;
    logic [AddrWidth-1:0] r_rsp_err_addr;
    logic [AddrWidth-1:0] w_err_addr_d;
    logic [AddrWidth-1:0] w_rsp_err_addr_d;
    logic [AddrWidth-1:0] w_head_addr;
    logic                 w_first_fail;

    assign w_head_addr  = w_head.addr[AddrWidth-1:0];
    // r_err set means an earlier burst of this transfer already failed.
    assign w_first_fail = w_pop & w_bresp_err & ~r_err;

    // Capture the first failing burst address and hand it to the response on last pop.
    always_comb begin
        w_err_addr_d     = r_err_addr;
        w_rsp_err_addr_d = r_rsp_err_addr;
        if (w_first_fail && !w_head.last) begin
            w_err_addr_d = w_head_addr;
        end
        if (w_pop && w_head.last) begin
            if (r_err) begin
                w_rsp_err_addr_d = r_err_addr;
            end else if (w_bresp_err) begin
                w_rsp_err_addr_d = w_head_addr;
            end else begin
                w_rsp_err_addr_d = '0;
            end
        end
    end

    // Error address registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_addr     <= '0;
            r_rsp_err_addr <= '0;
        end else begin
            r_err_addr     <= w_err_addr_d;
            r_rsp_err_addr <= w_rsp_err_addr_d;
        end
    end

    assign rsp_err_addr_o = r_rsp_err_addr;
`else
    assign rsp_err_addr_o = '0;
`endif

endmodule

// File: tb/tb_idma_w_burst_tracker.sv
// Directed, table-driven bench for idma_w_burst_tracker plus hand-written multi-cycle
// sequences (full FIFO, response back-pressure, mid-operation reset).
module tb_idma_w_burst_tracker;

    localparam int unsigned NumOut = 8;
    localparam int unsigned AW     = 24;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          aw_valid_i;
    logic          aw_ready_o;
    logic          aw_last_i;
    logic          aw_super_last_i;
    logic [AW-1:0] aw_addr_i;
    logic          b_valid_i;
    logic          b_ready_o;
    logic [1:0]    b_resp_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic          rsp_error_o;
    logic          rsp_last_o;
    logic [AW-1:0] rsp_err_addr_o;
    logic          busy_o;

    always #5 clk_i = ~clk_i;

    idma_w_burst_tracker #(
        .NumOutstanding (NumOut),
        .AddrWidth      (AW)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .aw_valid_i      (aw_valid_i),
        .aw_ready_o      (aw_ready_o),
        .aw_last_i       (aw_last_i),
        .aw_super_last_i (aw_super_last_i),
        .aw_addr_i       (aw_addr_i),
        .b_valid_i       (b_valid_i),
        .b_ready_o       (b_ready_o),
        .b_resp_i        (b_resp_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_error_o     (rsp_error_o),
        .rsp_last_o      (rsp_last_o),
        .rsp_err_addr_o  (rsp_err_addr_o),
        .busy_o          (busy_o)
    );

    typedef struct {
        logic          awv;
        logic          awl;
        logic          awsl;
        logic [AW-1:0] addr;
        logic          bv;
        logic [1:0]    resp;
        logic          rr;
        logic          e_awr;
        logic          e_br;
        logic          e_rv;
        logic          e_err;
        logic          e_last;
        logic          e_busy;
        logic [AW-1:0] e_eaddr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic awv, input logic awl, input logic awsl,
                         input logic [AW-1:0] addr, input logic bv, input logic [1:0] resp,
                         input logic rr);
        aw_valid_i      = awv;
        aw_last_i       = awl;
        aw_super_last_i = awsl;
        aw_addr_i       = addr;
        b_valid_i       = bv;
        b_resp_i        = resp;
        rsp_ready_i     = rr;
    endtask

    task automatic add(input logic awv, input logic awl, input logic awsl,
                       input logic [AW-1:0] addr, input logic bv, input logic [1:0] resp,
                       input logic rr, input logic e_awr, input logic e_br, input logic e_rv,
                       input logic e_err, input logic e_last, input logic e_busy,
                       input logic [AW-1:0] e_eaddr);
        vec_t v;
        v = '{awv, awl, awsl, addr, bv, resp, rr, e_awr, e_br, e_rv, e_err, e_last, e_busy,
              e_eaddr};
        vecs.push_back(v);
    endtask

    // Expected error address: tied to zero when the capture feature is compiled out.
    function automatic logic [AW-1:0] exp_eaddr(input logic [AW-1:0] a);
`ifdef IDMA_BTRACK_ERR_ADDR_EN
        return a;
`else
        return (a == a) ? '0 : '0;
`endif
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int pops;
        rst_ni = 1'b0;
        drive(0, 0, 0, '0, 0, 2'd0, 1);

        // Three-burst OKAY transfer
        add(0,0,0,24'h000, 0,2'd0,1,  1,0,0,0,0,0, 24'h000);
        add(1,0,0,24'h100, 0,2'd0,1,  1,0,0,0,0,0, 24'h000);
        add(1,0,0,24'h104, 0,2'd0,1,  1,1,0,0,0,1, 24'h000);
        add(1,1,0,24'h108, 0,2'd0,1,  1,1,0,0,0,1, 24'h000);
        add(0,0,0,24'h000, 1,2'd0,1,  1,1,0,0,0,1, 24'h000);
        add(0,0,0,24'h000, 1,2'd0,1,  1,1,0,0,0,1, 24'h000);
        add(0,0,0,24'h000, 1,2'd0,1,  1,1,0,0,0,1, 24'h000);
        add(0,0,0,24'h000, 0,2'd0,0,  1,0,1,0,0,1, 24'h000);
        add(0,0,0,24'h000, 0,2'd0,1,  1,0,1,0,0,1, 24'h000);
        add(0,0,0,24'h000, 0,2'd0,1,  1,0,0,0,0,0, 24'h000);
        // Two-burst super_last transfer, SLVERR then OKAY
        add(1,0,1,24'h200, 0,2'd0,0,  1,0,0,0,0,0, 24'h000);
        add(1,1,1,24'h204, 0,2'd0,0,  1,1,0,0,0,1, 24'h000);
        add(0,0,0,24'h000, 1,2'd2,0,  1,1,0,0,0,1, 24'h000);
        add(0,0,0,24'h000, 1,2'd0,0,  1,1,0,0,0,1, 24'h000);
        add(0,0,0,24'h000, 0,2'd0,1,  1,0,1,1,1,1, 24'h200);
        add(0,0,0,24'h000, 0,2'd0,1,  1,0,0,0,0,0, 24'h000);
        // Single bursts: EXOKAY is success, DECERR is failure
        add(1,1,0,24'h300, 0,2'd0,1,  1,0,0,0,0,0, 24'h000);
        add(0,0,0,24'h000, 1,2'd1,1,  1,1,0,0,0,1, 24'h000);
        add(1,1,1,24'h304, 0,2'd0,1,  1,0,1,0,0,1, 24'h000);
        add(0,0,0,24'h000, 1,2'd3,0,  1,1,0,0,0,1, 24'h000);
        add(0,0,0,24'h000, 0,2'd0,0,  1,0,1,1,1,1, 24'h304);
        add(0,0,0,24'h000, 0,2'd0,1,  1,0,1,1,1,1, 24'h304);
        add(0,0,0,24'h000, 0,2'd0,1,  1,0,0,0,0,0, 24'h000);
        // B with the FIFO empty is not accepted and changes nothing
        add(0,0,0,24'h000, 1,2'd2,1,  1,0,0,0,0,0, 24'h000);
        add(0,0,0,24'h000, 0,2'd0,1,  1,0,0,0,0,0, 24'h000);

        // Reset values
        repeat (2) @(negedge clk_i);
        #1;
        check("reset_aw_ready", aw_ready_o, 1);
        check("reset_b_ready", b_ready_o, 0);
        check("reset_rsp_valid", rsp_valid_o, 0);
        check("reset_rsp_error", rsp_error_o, 0);
        check("reset_rsp_last", rsp_last_o, 0);
        check("reset_busy", busy_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk_i);
            drive(vecs[i].awv, vecs[i].awl, vecs[i].awsl, vecs[i].addr, vecs[i].bv,
                  vecs[i].resp, vecs[i].rr);
            #1;
            check($sformatf("v%0d_aw_ready", i), aw_ready_o, vecs[i].e_awr);
            check($sformatf("v%0d_b_ready", i), b_ready_o, vecs[i].e_br);
            check($sformatf("v%0d_rsp_valid", i), rsp_valid_o, vecs[i].e_rv);
            check($sformatf("v%0d_busy", i), busy_o, vecs[i].e_busy);
            if (vecs[i].e_rv) begin
                check($sformatf("v%0d_rsp_error", i), rsp_error_o, vecs[i].e_err);
                check($sformatf("v%0d_rsp_last", i), rsp_last_o, vecs[i].e_last);
                check($sformatf("v%0d_err_addr", i), rsp_err_addr_o,
                      exp_eaddr(vecs[i].e_eaddr));
            end
        end

        // Fill to NumOut with no B
        for (int k = 0; k < int'(NumOut); k++) begin
            @(negedge clk_i);
            drive(1, 0, 0, AW'(16 * k), 0, 2'd0, 1);
            #1;
            check($sformatf("fill%0d_aw_ready", k), aw_ready_o, 1);
        end
        @(negedge clk_i);
        drive(0, 0, 0, '0, 0, 2'd0, 1);
        #1;
        check("full_aw_ready", aw_ready_o, 0);
        check("full_b_ready", b_ready_o, 1);
        // Push attempt while full alongside a pop: push stays blocked
        @(negedge clk_i);
        drive(1, 0, 0, 24'hAAA, 1, 2'd0, 1);
        #1;
        check("full_pushpop_aw_ready", aw_ready_o, 0);
        @(negedge clk_i);
        drive(0, 0, 0, '0, 0, 2'd0, 1);
        #1;
        check("reopen_aw_ready", aw_ready_o, 1);
        // Push and pop together at seven: occupancy must stay seven
        @(negedge clk_i);
        drive(1, 0, 0, 24'hBBB, 1, 2'd0, 1);
        #1;
        check("pushpop_aw_ready", aw_ready_o, 1);
        check("pushpop_b_ready", b_ready_o, 1);
        @(negedge clk_i);
        drive(0, 0, 0, '0, 0, 2'd0, 1);
        #1;
        check("pushpop_hold_aw_ready", aw_ready_o, 1);
        @(negedge clk_i);
        drive(1, 0, 0, 24'hCCC, 0, 2'd0, 1);
        @(negedge clk_i);
        drive(0, 0, 0, '0, 0, 2'd0, 1);
        #1;
        check("refull_aw_ready", aw_ready_o, 0);
        // Drain, counting accepted B responses
        pops = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            drive(0, 0, 0, '0, 1, 2'd0, 1);
            #1;
            if (!b_ready_o) break;
            pops++;
        end
        check("drain_pop_count", pops, NumOut);
        @(negedge clk_i);
        drive(0, 0, 0, '0, 0, 2'd0, 1);
        #1;
        check("drain_busy", busy_o, 0);
        check("drain_rsp_valid", rsp_valid_o, 0);

        // Two single-burst transfers with the response held
        @(negedge clk_i);
        drive(1, 1, 0, 24'h400, 0, 2'd0, 0);
        @(negedge clk_i);
        drive(1, 1, 1, 24'h404, 0, 2'd0, 0);
        @(negedge clk_i);
        drive(0, 0, 0, '0, 1, 2'd0, 0);
        #1;
        check("stall_first_b_ready", b_ready_o, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            drive(0, 0, 0, '0, 1, 2'd0, 0);
            #1;
            check($sformatf("stall%0d_b_ready", k), b_ready_o, 0);
            check($sformatf("stall%0d_rsp_valid", k), rsp_valid_o, 1);
            check($sformatf("stall%0d_rsp_last", k), rsp_last_o, 0);
        end
        @(negedge clk_i);
        drive(0, 0, 0, '0, 1, 2'd0, 1);
        #1;
        check("stall_release_b_ready", b_ready_o, 1);
        check("stall_release_rsp_last", rsp_last_o, 0);
        @(negedge clk_i);
        drive(0, 0, 0, '0, 0, 2'd0, 0);
        #1;
        check("second_rsp_valid", rsp_valid_o, 1);
        check("second_rsp_last", rsp_last_o, 1);
        check("second_rsp_error", rsp_error_o, 0);
        @(negedge clk_i);
        drive(0, 0, 0, '0, 0, 2'd0, 1);
        #1;
        check("second_rsp_hold", rsp_valid_o, 1);
        @(negedge clk_i);
        #1;
        check("second_drained", rsp_valid_o, 0);
        check("second_busy", busy_o, 0);

        // Mid-operation reset with three outstanding and the sticky error set
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            drive(1, (k == 3), 0, AW'(24'h500 + 4 * k), 0, 2'd0, 1);
        end
        @(negedge clk_i);
        drive(0, 0, 0, '0, 1, 2'd2, 1);
        #1;
        check("prereset_b_ready", b_ready_o, 1);
        @(negedge clk_i);
        drive(0, 0, 0, '0, 0, 2'd0, 1);
        #1;
        check("prereset_busy", busy_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midreset_aw_ready", aw_ready_o, 1);
        check("midreset_b_ready", b_ready_o, 0);
        check("midreset_rsp_valid", rsp_valid_o, 0);
        check("midreset_rsp_error", rsp_error_o, 0);
        check("midreset_busy", busy_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        drive(1, 1, 0, 24'h600, 0, 2'd0, 1);
        @(negedge clk_i);
        drive(0, 0, 0, '0, 1, 2'd0, 1);
        #1;
        check("postreset_b_ready", b_ready_o, 1);
        @(negedge clk_i);
        drive(0, 0, 0, '0, 0, 2'd0, 1);
        #1;
        check("postreset_rsp_valid", rsp_valid_o, 1);
        check("postreset_rsp_error", rsp_error_o, 0);
        check("postreset_err_addr", rsp_err_addr_o, 0);
        @(negedge clk_i);
        #1;
        check("postreset_idle", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
